ctrl_resolve: RTL and testbench
===============================

# ctrl_resolve

Branch-resolution consumer for the execute stage's control ALU. Takes each resolved control-transfer result (PC, computed next PC, direction, execution flags), queues a predictor/BTB training update, and on a mispredict sequences the recovery: front-end flush, wait for map-table restore, then a single-cycle fetch redirect to the correct target. Sits between the control execute lane and fetch/branch predictor/rename recovery.

## Interface
- SIZE_PC, 32, PC/target width
- TAG_W, 4, control-transfer tag width
- UPD_DEPTH, 4, update FIFO entries (power of 2, ≥2)
- FLUSH_CYCLES, 2, cycles flush_o is held (≥1)
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- exeValid_i  in  1  result present from control ALU
- exeReady_o  out  1  result accepted this cycle when high with exeValid_i
- exePC_i  in  SIZE_PC  PC of control instruction
- exeNextPC_i  in  SIZE_PC  resolved next PC
- exeDirection_i  in  1  resolved taken
- exeFlags_i  in  8  execution flags: bit0 mispredict, bit2 executed, bit5 conditional
- exeTag_i  in  TAG_W  control-transfer tag
- flush_o  out  1  front-end/wrong-path squash
- flushTag_o  out  TAG_W  tag of mispredicting instruction, valid while flush_o
- recoverDone_i  in  1  rename/ROB restore complete
- redirectValid_o  out  1  one-cycle fetch redirect
- redirectPC_o  out  SIZE_PC  redirect target
- updValid_o / updReady_i  out / in  1 / 1  predictor update handshake
- updPC_o, updTarget_o  out  SIZE_PC  update PC, resolved target
- updDir_o, updCond_o  out  1 each  resolved direction, conditional flag
- mispredCount_o  out  16  saturating mispredict count
- busy_o  out  1  state != IDLE

## Operation
- Accept = exeValid_i & exeReady_o. exeReady_o = (state==IDLE) & !fifoFull (registered full; no same-cycle pop bypass).
- Accepted result with flags[2]=1 pushes {PC, NextPC, Direction, flags[5]} to update FIFO. flags[2]=0: accepted, discarded, no other effect.
- Accepted with flags[2]=1 and flags[0]=1: entry still pushed (predictor trains on true outcome); target and tag latched; mispredCount_o +1 (saturates at 0xFFFF); state → FLUSH.
- FSM: IDLE → FLUSH (counter loads FLUSH_CYCLES) → WAIT_RECOVER → REDIRECT → IDLE.
- FLUSH: flush_o=1, flushTag_o=latched tag; counter decrements; leave when counter reaches 1.
- WAIT_RECOVER: wait for recoverDone_i=1; recoverDone_i outside this state ignored.
- REDIRECT: redirectValid_o=1, redirectPC_o=latched target, exactly one cycle.
- FIFO: pop on updValid_o & updReady_i; updValid_o = !empty; drains in all states. Push and pop same cycle when not full: count unchanged. Pointers wrap modulo UPD_DEPTH; count width clog2(UPD_DEPTH+1).
- Reset (any time, mid-recovery included): state IDLE, FIFO empty, counters 0, no redirect/flush issued.

## Timing
- Reset values: exeReady_o=1, flush_o=0, flushTag_o=0, redirectValid_o=0, redirectPC_o=0, updValid_o=0, upd* data=0, mispredCount_o=0, busy_o=0.
- Mispredict accepted in cycle T: flush_o high T+1..T+FLUSH_CYCLES; exeReady_o low from T+1.
- recoverDone_i high in WAIT_RECOVER cycle R: redirectValid_o high in R+1 only; IDLE and exeReady_o high at R+2 (if FIFO not full).
- Update latency: pushed entry visible on upd* the cycle after accept when FIFO was empty.
- All outputs registered or decoded from registered state; no input-to-output combinational path except none (exeReady_o depends only on state/count).

## Structure
- Package ctrl_resolve_pkg: flag bit indices (FLAG_MISPRED=0, FLAG_EXEC=2, FLAG_COND=5), FSM state enum, update-entry struct {pc, target, dir, cond}.
- Sub-module ctrl_upd_fifo: parameterized synchronous FIFO (push/pop, full/empty, count), async active-low reset.
- Top holds FSM, flush counter, target/tag latch, mispredict counter.

## Test plan
- Reset then 3 correct branches (flags=0x24, PCs 0x100/0x108/0x110), updReady_i=1 → 3 updates in order, flush_o never high.
- Mispredict at PC 0x200, nextPC 0x400, tag 3, FLUSH_CYCLES=2 → flush_o/flushTag_o=3 two cycles, exeReady_o low; recoverDone_i at cycle R → redirectValid_o=1, redirectPC_o=0x400 at R+1 only; mispredCount_o=1.
- updReady_i=0, push 4 results → exeReady_o=0 with 4 entries; 5th held; raise updReady_i → one pop, 5th accepted next cycle, order preserved.
- recoverDone_i pulsed during FLUSH → ignored; redirect only after pulse in WAIT_RECOVER.
- flags[2]=0 result → accepted, no update, no flush.
- Assert reset during WAIT_RECOVER with 2 FIFO entries → all outputs at reset values, no redirect after release.

Source files
------------

// File: rtl/ctrl_resolve_pkg.sv
// Shared definitions for the control-transfer resolution block:
// execution flag bit positions, recovery FSM states and the predictor update entry.
package ctrl_resolve_pkg;

  localparam int unsigned FLAG_MISPRED = 0;
  localparam int unsigned FLAG_EXEC    = 2;
  localparam int unsigned FLAG_COND    = 5;

  localparam int unsigned PC_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_WAIT_RECOVER,
    ST_REDIRECT
  } state_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] target;
    logic            dir;
    logic            cond;
  } upd_entry_t;

endpackage

// File: rtl/ctrl_upd_fifo.sv
// Synchronous FIFO holding pending predictor/BTB training updates.
// Head entry is read straight from storage; full/empty derive from the registered count.
module ctrl_upd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ctrl_resolve.sv
// Branch-resolution consumer: queues predictor training updates and sequences
// mispredict recovery (flush, wait for map restore, one-cycle fetch redirect).
module ctrl_resolve
  import ctrl_resolve_pkg::*;
#(
  parameter int unsigned SIZE_PC      = PC_W,
  parameter int unsigned TAG_W        = 4,
  parameter int unsigned UPD_DEPTH    = 4,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               exeValid_i,
  output logic               exeReady_o,
  input  logic [SIZE_PC-1:0] exePC_i,
  input  logic [SIZE_PC-1:0] exeNextPC_i,
  input  logic               exeDirection_i,
  input  logic [7:0]         exeFlags_i,
  input  logic [TAG_W-1:0]   exeTag_i,
  output logic               flush_o,
  output logic [TAG_W-1:0]   flushTag_o,
  input  logic               recoverDone_i,
  output logic               redirectValid_o,
  output logic [SIZE_PC-1:0] redirectPC_o,
  output logic               updValid_o,
  input  logic               updReady_i,
  output logic [SIZE_PC-1:0] updPC_o,
  output logic [SIZE_PC-1:0] updTarget_o,
  output logic               updDir_o,
  output logic               updCond_o,
  output logic [15:0]        mispredCount_o,
  output logic               busy_o
);
  localparam int unsigned CNT_W     = $clog2(FLUSH_CYCLES + 1);
  localparam int unsigned UPD_CNT_W = $clog2(UPD_DEPTH + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SIZE_PC-1:0] target_q, target_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [15:0]        mis_cnt_q, mis_cnt_d;

  logic accept, push, pop, mispred;
  logic fifo_full, fifo_empty;
  upd_entry_t push_entry, head_entry;
  logic [UPD_CNT_W-1:0] fifo_count_unused;
  logic unused_flags;

  assign unused_flags = ^{exeFlags_i[7:6], exeFlags_i[4:3], exeFlags_i[1]};

  assign accept  = exeValid_i & exeReady_o;
  assign push    = accept & exeFlags_i[FLAG_EXEC];
  assign mispred = push & exeFlags_i[FLAG_MISPRED];
  assign pop     = updReady_i & ~fifo_empty;

  always_comb begin
    push_entry        = '0;
    push_entry.pc     = exePC_i;
    push_entry.target = exeNextPC_i;
    push_entry.dir    = exeDirection_i;
    push_entry.cond   = exeFlags_i[FLAG_COND];
  end

  ctrl_upd_fifo #(
    .WIDTH ($bits(upd_entry_t)),
    .DEPTH (UPD_DEPTH)
  ) u_upd_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_unused)
  );

  assign updValid_o  = ~fifo_empty;
  assign updPC_o     = head_entry.pc;
  assign updTarget_o = head_entry.target;
  assign updDir_o    = head_entry.dir;
  assign updCond_o   = head_entry.cond;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:         if (mispred) state_d = ST_FLUSH;
      ST_FLUSH:        if (cnt_q == CNT_W'(1)) state_d = ST_WAIT_RECOVER;
      ST_WAIT_RECOVER: if (recoverDone_i) state_d = ST_REDIRECT;
      ST_REDIRECT:     state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    exeReady_o      = (state_q == ST_IDLE) & ~fifo_full;
    flush_o         = (state_q == ST_FLUSH);
    redirectValid_o = (state_q == ST_REDIRECT);
    busy_o          = (state_q != ST_IDLE);
  end

  // Mispredict accept loads the flush length and captures target/tag for the recovery sequence.
  always_comb begin
    cnt_d     = cnt_q;
    target_d  = target_q;
    tag_d     = tag_q;
    mis_cnt_d = mis_cnt_q;
    if (mispred) begin
      cnt_d    = CNT_W'(FLUSH_CYCLES);
      target_d = exeNextPC_i;
      tag_d    = exeTag_i;
      if (mis_cnt_q != '1) mis_cnt_d = mis_cnt_q + 16'd1;
    end else if (state_q == ST_FLUSH && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      target_q  <= '0;
      tag_q     <= '0;
      mis_cnt_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      target_q  <= target_d;
      tag_q     <= tag_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign flushTag_o     = tag_q;
  assign redirectPC_o   = target_q;
  assign mispredCount_o = mis_cnt_q;

endmodule

// File: tb/tb_ctrl_resolve.sv
// Scoreboard bench for ctrl_resolve: directed scenarios plus randomized results,
// expected updates/redirects queued at issue and checked by an independent monitor.
module tb_ctrl_resolve;
  localparam int unsigned SIZE_PC      = 32;
  localparam int unsigned TAG_W        = 4;
  localparam int unsigned UPD_DEPTH    = 4;
  localparam int unsigned FLUSH_CYCLES = 2;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               exeValid_i = 1'b0;
  logic               exeReady_o;
  logic [SIZE_PC-1:0] exePC_i = '0;
  logic [SIZE_PC-1:0] exeNextPC_i = '0;
  logic               exeDirection_i = 1'b0;
  logic [7:0]         exeFlags_i = '0;
  logic [TAG_W-1:0]   exeTag_i = '0;
  logic               flush_o;
  logic [TAG_W-1:0]   flushTag_o;
  logic               recoverDone_i = 1'b0;
  logic               redirectValid_o;
  logic [SIZE_PC-1:0] redirectPC_o;
  logic               updValid_o;
  logic               updReady_i = 1'b0;
  logic [SIZE_PC-1:0] updPC_o;
  logic [SIZE_PC-1:0] updTarget_o;
  logic               updDir_o;
  logic               updCond_o;
  logic [15:0]        mispredCount_o;
  logic               busy_o;

  always #5 clk = ~clk;

  ctrl_resolve #(
    .SIZE_PC      (SIZE_PC),
    .TAG_W        (TAG_W),
    .UPD_DEPTH    (UPD_DEPTH),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .exeValid_i      (exeValid_i),
    .exeReady_o      (exeReady_o),
    .exePC_i         (exePC_i),
    .exeNextPC_i     (exeNextPC_i),
    .exeDirection_i  (exeDirection_i),
    .exeFlags_i      (exeFlags_i),
    .exeTag_i        (exeTag_i),
    .flush_o         (flush_o),
    .flushTag_o      (flushTag_o),
    .recoverDone_i   (recoverDone_i),
    .redirectValid_o (redirectValid_o),
    .redirectPC_o    (redirectPC_o),
    .updValid_o      (updValid_o),
    .updReady_i      (updReady_i),
    .updPC_o         (updPC_o),
    .updTarget_o     (updTarget_o),
    .updDir_o        (updDir_o),
    .updCond_o       (updCond_o),
    .mispredCount_o  (mispredCount_o),
    .busy_o          (busy_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        dir;
    logic        cond;
  } upd_t;

  upd_t        exp_upd[$];
  logic [31:0] exp_redir[$];
  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned exp_mis = 0;
  bit          flush_allowed = 1'b0;
  bit          mon_on = 1'b0;
  bit          rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) updReady_i = ($urandom_range(0, 3) != 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT hands over an update or a redirect.
  always @(negedge clk) begin
    if (mon_on && reset) begin
      chk("upd_valid", 64'(updValid_o), 64'(exp_upd.size() != 0));
      chk("flush_unexpected", 64'(flush_o & ~flush_allowed), 64'(0));
      if (updValid_o && updReady_i && exp_upd.size() != 0) begin
        upd_t e;
        e = exp_upd.pop_front();
        chk("upd_pc", 64'(updPC_o), 64'(e.pc));
        chk("upd_target", 64'(updTarget_o), 64'(e.tgt));
        chk("upd_dir", 64'(updDir_o), 64'(e.dir));
        chk("upd_cond", 64'(updCond_o), 64'(e.cond));
      end
      if (redirectValid_o) begin
        if (exp_redir.size() == 0) chk("redirect_unexpected", 64'(1), 64'(0));
        else chk("redirect_pc", 64'(redirectPC_o), 64'(exp_redir.pop_front()));
      end
    end
  end

  task automatic reset_vals(input string tag);
    chk({tag, "_exeReady"}, 64'(exeReady_o), 64'(1));
    chk({tag, "_flush"}, 64'(flush_o), 64'(0));
    chk({tag, "_flushTag"}, 64'(flushTag_o), 64'(0));
    chk({tag, "_redirValid"}, 64'(redirectValid_o), 64'(0));
    chk({tag, "_redirPC"}, 64'(redirectPC_o), 64'(0));
    chk({tag, "_updValid"}, 64'(updValid_o), 64'(0));
    chk({tag, "_updData"}, 64'({updPC_o, updTarget_o} | 64'({updDir_o, updCond_o})), 64'(0));
    chk({tag, "_misCount"}, 64'(mispredCount_o), 64'(0));
    chk({tag, "_busy"}, 64'(busy_o), 64'(0));
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] npc, input logic dir,
                      input logic [7:0] fl, input logic [3:0] tag,
                      input bit recover, input bit pulse_in_flush);
    bit acc = 1'b0;
    exeValid_i = 1'b1; exePC_i = pc; exeNextPC_i = npc;
    exeDirection_i = dir; exeFlags_i = fl; exeTag_i = tag;
    for (int c = 0; c < 60 && !acc; c++) begin
      @(negedge clk);
      acc = exeReady_o;
      tick();
    end
    exeValid_i = 1'b0;
    if (!acc) begin
      chk("accept_timeout", 64'(0), 64'(1));
      return;
    end
    if (fl[2]) exp_upd.push_back('{pc, npc, dir, fl[5]});
    if (fl[2] && fl[0]) begin
      if (exp_mis != 32'hFFFF) exp_mis++;
      flush_allowed = 1'b1;
      for (int i = 0; i < FLUSH_CYCLES; i++) begin
        recoverDone_i = (i == 0) ? pulse_in_flush : 1'b0;
        @(negedge clk);
        chk("flush_high", 64'(flush_o), 64'(1));
        chk("flush_tag", 64'(flushTag_o), 64'(tag));
        chk("ready_low_in_flush", 64'(exeReady_o), 64'(0));
        tick();
      end
      recoverDone_i = 1'b0;
      flush_allowed = 1'b0;
      if (recover) begin
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          chk("wait_no_redirect", 64'(redirectValid_o), 64'(0));
          chk("wait_busy", 64'(busy_o), 64'(1));
          tick();
        end
        recoverDone_i = 1'b1;
        exp_redir.push_back(npc);
        tick();
        recoverDone_i = 1'b0;
        @(negedge clk);
        chk("redirect_valid", 64'(redirectValid_o), 64'(1));
        tick();
        @(negedge clk);
        chk("redirect_one_cycle", 64'(redirectValid_o), 64'(0));
        chk("idle_after_redirect", 64'(busy_o), 64'(0));
        tick();
      end
    end
    @(negedge clk);
    chk("mispred_count", 64'(mispredCount_o), 64'(exp_mis));
    tick();
  endtask

  task automatic drain();
    updReady_i = 1'b1;
    for (int c = 0; c < 20 && exp_upd.size() != 0; c++) tick();
    chk("drained", 64'(exp_upd.size()), 64'(0));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_vals("reset");
    tick();
    reset = 1'b1;
    mon_on = 1'b1;
    updReady_i = 1'b1;
    tick();

    for (int k = 0; k < 3; k++) begin
      send(32'h100 + 32'(8 * k), 32'h180 + 32'(4 * k), 1'(k & 1), 8'h24, 4'(k), 1'b1, 1'b0);
    end

    send(32'h200, 32'h400, 1'b1, 8'h25, 4'd3, 1'b1, 1'b1);
    chk("mispred_count_one", 64'(mispredCount_o), 64'(1));

    drain();
    updReady_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send(32'h300 + 32'(8 * k), 32'h340 + 32'(8 * k), 1'b1, 8'h24, 4'd0, 1'b1, 1'b0);
    end
    @(negedge clk);
    chk("full_not_ready", 64'(exeReady_o), 64'(0));
    tick();
    fork
      send(32'h320, 32'h360, 1'b0, 8'h04, 4'd0, 1'b1, 1'b0);
      begin
        repeat (2) begin
          @(negedge clk);
          chk("held_while_full", 64'(exeReady_o), 64'(0));
          tick();
        end
        updReady_i = 1'b1;
        tick();
        updReady_i = 1'b0;
        @(negedge clk);
        chk("ready_after_pop", 64'(exeReady_o), 64'(1));
      end
    join
    drain();

    send(32'h700, 32'h800, 1'b1, 8'h20, 4'd7, 1'b1, 1'b0);
    send(32'h704, 32'h900, 1'b0, 8'h21, 4'd8, 1'b1, 1'b0);
    @(negedge clk);
    chk("no_exec_idle", 64'(busy_o), 64'(0));
    tick();

    rand_rdy = 1'b1;
    for (int n = 0; n < 40; n++) begin
      logic [7:0] fl;
      fl = 8'($urandom_range(0, 255));
      fl[2] = ($urandom_range(0, 4) != 0);
      fl[0] = ($urandom_range(0, 3) == 0);
      send($urandom & 32'hFFFF_FFFC, $urandom, 1'($urandom_range(0, 1)), fl,
           4'($urandom_range(0, 15)), 1'b1, 1'($urandom_range(0, 1)));
    end
    rand_rdy = 1'b0;
    drain();

    updReady_i = 1'b0;
    send(32'h500, 32'h540, 1'b1, 8'h24, 4'd1, 1'b1, 1'b0);
    send(32'h600, 32'hA00, 1'b1, 8'h25, 4'd5, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_reset_busy", 64'(busy_o), 64'(1));
    tick();
    reset = 1'b0;
    exp_upd.delete();
    exp_redir.delete();
    exp_mis = 0;
    recoverDone_i = 1'b1;
    #1;
    reset_vals("midreset");
    tick();
    tick();
    reset = 1'b1;
    tick();
    recoverDone_i = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_reset_no_redirect", 64'(redirectValid_o), 64'(0));
      chk("post_reset_idle", 64'(busy_o), 64'(0));
      chk("post_reset_count", 64'(mispredCount_o), 64'(0));
      tick();
    end

    drain();
    chk("redirects_consumed", 64'(exp_redir.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
